// File: rtl/redun_mont.sv
// Free-running word-serial CIOS Montgomery squarer: after a seed load it keeps
// squaring its own result, x <- x*x*R^-1 mod P, and strobes each result out.
module redun_mont #(
    parameter int                  DAT_BITS = 1024,
    parameter int                  WRD_BITS = 16,
    parameter int                  NUM_WRDS = DAT_BITS / WRD_BITS + 1,
    parameter logic [DAT_BITS-1:0] P        = DAT_BITS'({8{128'hF1E2D3C4B5A69788796A5B4C3D2E1F0F}})
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]    i_sq,
    input  logic                                i_val,
    output logic [NUM_WRDS*(WRD_BITS+1)-1:0]    o_mul,
    output logic                                o_val,
    output logic [1:0]                          o_state
);

    localparam int RED_W = NUM_WRDS * (WRD_BITS + 1);
    localparam int BIN_W = NUM_WRDS * WRD_BITS;
    localparam int RES_W = BIN_W + WRD_BITS;
    localparam int ACC_W = DAT_BITS + WRD_BITS + 2;
    localparam int CNT_W = $clog2(NUM_WRDS + 1);

    // -P^-1 mod 2^WRD_BITS by Newton iteration; p0 is its own inverse mod 8.
    function automatic logic [WRD_BITS-1:0] neg_inv(input logic [WRD_BITS-1:0] p0);
        logic [WRD_BITS-1:0] x;
        x = p0;
        for (int k = 0; k < 6; k++) begin
            x = x * (WRD_BITS'(2) - p0 * x);
        end
        return -x;
    endfunction

    localparam logic [WRD_BITS-1:0] P_INV = neg_inv(P[WRD_BITS-1:0]);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        REDUCE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [RED_W-1:0]      sq_r;
    logic [DAT_BITS-1:0]   a_bin;
    logic [RES_W-1:0]      a_sh;
    logic [ACC_W-1:0]      t;
    logic [CNT_W-1:0]      cnt;

    logic [RES_W-1:0]      res_lo;
    logic [RES_W-1:0]      res_hi;
    logic [RES_W-1:0]      res;
    logic [WRD_BITS-1:0]   a_i;
    logic [WRD_BITS-1:0]   m;
    logic [ACC_W-1:0]      u;
    logic [ACC_W-1:0]      v;
    logic [ACC_W-1:0]      t_step;
    logic [BIN_W-1:0]      t_sub;
    logic [RED_W-1:0]      red_out;
    logic                  last_wrd;

    assign o_state  = state;
    assign last_wrd = (cnt == CNT_W'(NUM_WRDS));

    // o_val is a single-cycle strobe with no back-pressure: o_mul is valid and
    // new in exactly the cycle o_val is high, and holds until the next strobe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_val) state_nxt = MUL;
            MUL:     if (last_wrd) state_nxt = REDUCE;
            REDUCE:  state_nxt = MUL;
            default: state_nxt = IDLE;
        endcase
        if (i_val) begin
            state_nxt = MUL;
        end
    end

    // Carry resolution: low word bits and the shifted-up carry bits form two
    // binary numbers whose sum is the represented value.
    always_comb begin
        res_lo = '0;
        res_hi = '0;
        for (int i = 0; i < NUM_WRDS; i++) begin
            res_lo[WRD_BITS*i +: WRD_BITS] = sq_r[(WRD_BITS+1)*i +: WRD_BITS];
            res_hi[WRD_BITS*(i+1)]         = sq_r[(WRD_BITS+1)*i + WRD_BITS];
        end
        res = res_lo + res_hi;
    end

    always_comb begin
        a_i    = a_sh[WRD_BITS-1:0];
        u      = t + ACC_W'(a_i) * ACC_W'(a_bin);
        m      = u[WRD_BITS-1:0] * P_INV;
        v      = u + ACC_W'(m) * ACC_W'(P);
        t_step = v >> WRD_BITS;
    end

    // t < 2P after the word loop, so one conditional subtract fully reduces.
    always_comb begin
        t_sub   = BIN_W'((t >= ACC_W'(P)) ? t - ACC_W'(P) : t);
        red_out = '0;
        for (int i = 0; i < NUM_WRDS; i++) begin
            red_out[(WRD_BITS+1)*i +: WRD_BITS+1] = {1'b0, t_sub[WRD_BITS*i +: WRD_BITS]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sq_r  <= '0;
            a_bin <= '0;
            a_sh  <= '0;
            t     <= '0;
            cnt   <= '0;
            o_mul <= '0;
            o_val <= 1'b0;
        end else begin
            o_val <= 1'b0;
            if (i_val) begin
                sq_r <= i_sq;
                t    <= '0;
                cnt  <= '0;
            end else begin
                case (state)
                    MUL: begin
                        // The first MUL cycle resolves the operand; the rest step one word each.
                        if (cnt == '0) begin
                            a_bin <= res[DAT_BITS-1:0];
                            a_sh  <= res;
                            t     <= '0;
                        end else begin
                            t     <= t_step;
                            a_sh  <= a_sh >> WRD_BITS;
                        end
                        cnt <= cnt + 1'b1;
                    end
                    REDUCE: begin
                        o_mul <= red_out;
                        o_val <= 1'b1;
                        sq_r  <= red_out;
                        t     <= '0;
                        cnt   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_redun_mont.sv
// Directed bench for redun_mont: a bit-serial Montgomery model fills an
// expected-result queue at each seed load; strobes pop and compare it.
module tb_redun_mont;

    localparam int DW = 1024;
    localparam int WB = 16;
    localparam int NW = DW / WB + 1;
    localparam int RW = NW * (WB + 1);
    localparam int RB = NW * WB;
    localparam int VW = RB + WB;
    localparam int EW = 2 * DW + 2;
    localparam int L  = NW + 2;
    localparam logic [DW-1:0] P = {8{128'hF1E2D3C4B5A69788796A5B4C3D2E1F0F}};

    logic          clk = 1'b0;
    logic          rst;
    logic          val_in;
    logic [RW-1:0] sq;
    logic [RW-1:0] mul;
    logic          mul_v;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    redun_mont #(.DAT_BITS(DW), .WRD_BITS(WB), .P(P)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sq    (sq),
        .i_val   (val_in),
        .o_mul   (mul),
        .o_val   (mul_v),
        .o_state (dbg_state)
    );

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            due = 0;
    bit            armed = 1'b0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] last_mul;

    // Montgomery reduction one bit at a time: t * 2^-RB mod P.
    function automatic logic [DW-1:0] mont_red(input logic [EW-1:0] t_in);
        logic [EW-1:0] t;
        t = t_in;
        for (int i = 0; i < RB; i++) begin
            if (t[0]) t = t + EW'(P);
            t = t >> 1;
        end
        if (t >= EW'(P)) t = t - EW'(P);
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mont_sq(input logic [DW-1:0] x);
        return mont_red(EW'(x) * EW'(x));
    endfunction

    function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] to_mont(input logic [DW-1:0] a);
        logic [DW-1:0] r;
        r = a;
        repeat (RB) r = add_mod(r, r);
        return r;
    endfunction

    function automatic logic [DW-1:0] mul_mod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] r;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            r = add_mod(r, r);
            if (y[i]) r = add_mod(r, x);
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] to_redun(input logic [DW-1:0] x);
        logic [RB-1:0] xe;
        logic [RW-1:0] r;
        xe = RB'(x);
        r  = '0;
        for (int i = 0; i < NW; i++) r[(WB+1)*i +: WB+1] = {1'b0, xe[WB*i +: WB]};
        return r;
    endfunction

    // Same value, but borrow one unit from every odd word into the carry bit below it.
    function automatic logic [RW-1:0] to_redun_carry(input logic [DW-1:0] x);
        logic [RW-1:0] r;
        r = to_redun(x);
        for (int i = 0; i < NW - 1; i += 2) begin
            if (r[(WB+1)*(i+1) +: WB] != '0) begin
                r[(WB+1)*(i+1) +: WB+1] = r[(WB+1)*(i+1) +: WB+1] - 17'd1;
                r[(WB+1)*i + WB]        = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] from_redun(input logic [RW-1:0] r);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) v = v + (VW'(r[(WB+1)*i +: WB+1]) << (WB * i));
        return v[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    endtask

    task automatic step();
        logic exp_v;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_v = armed && (cyc == due) && (exp_q.size() != 0);
        if (exp_v || mul_v) chk("o_val timing", RW'(mul_v), RW'(exp_v));
        if (exp_v) begin
            chk("o_mul value", mul, exp_q.pop_front());
            last_mul = mul;
            due      = due + L;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic load(input logic [RW-1:0] seed, input logic [DW-1:0] x0, input int n, input int hold);
        logic [DW-1:0] x;
        exp_q.delete();
        armed  = 1'b0;
        sq     = seed;
        val_in = 1'b1;
        repeat (hold) step();
        val_in = 1'b0;
        due    = cyc + L;
        armed  = 1'b1;
        x      = x0;
        for (int k = 0; k < n; k++) begin
            x = mont_sq(x);
            exp_q.push_back(to_redun(x));
        end
    endtask

    task automatic rand_mod(output logic [DW-1:0] v);
        for (int k = 0; k < DW / 32; k++) v[32*k +: 32] = $urandom();
        if (v >= P) v = v - P;
    endtask

    logic [DW-1:0] r_mont;
    logic [DW-1:0] a_rnd;
    logic [DW-1:0] a_pow;
    logic [DW-1:0] x_a;
    logic [DW-1:0] b_rnd;
    logic [DW-1:0] x_b;

    initial begin
        rst    = 1'b0;
        val_in = 1'b0;
        sq     = '0;
        run(3);
        chk("reset o_val", RW'(mul_v), '0);
        chk("reset o_mul", mul, '0);
        chk("reset state", RW'(dbg_state), RW'(2'd0));

        // Loads during reset are ignored: nothing may strobe after release.
        sq     = to_redun(DW'(1));
        val_in = 1'b1;
        run(2);
        val_in = 1'b0;
        rst    = 1'b1;
        run(L + 5);
        chk("idle o_mul", mul, '0);

        // One in Montgomery form is a fixed point of squaring.
        r_mont = to_mont(DW'(1));
        load(to_redun(r_mont), r_mont, 3, 1);
        run(3 * L);
        chk("queue drained one", RW'(exp_q.size()), '0);
        chk("one fixed point", RW'(from_redun(last_mul)), RW'(r_mont));

        load('0, '0, 3, 1);
        run(3 * L);
        chk("queue drained zero", RW'(exp_q.size()), '0);

        // Long chain from a random value: 127 squarings.
        void'($urandom(2));
        rand_mod(a_rnd);
        x_a = to_mont(a_rnd);
        load(to_redun(x_a), x_a, 127, 1);
        run(127 * L);
        chk("queue drained chain", RW'(exp_q.size()), '0);
        a_pow = a_rnd;
        repeat (127) a_pow = mul_mod(a_pow, a_pow);
        chk("from_mont a^(2^127)", RW'(mont_red(EW'(from_redun(last_mul)))), RW'(a_pow));

        // Redundant seed encoding must give the canonical results.
        rand_mod(b_rnd);
        x_b = to_mont(b_rnd);
        load(to_redun_carry(x_b), x_b, 2, 1);
        run(2 * L);
        chk("queue drained redun", RW'(exp_q.size()), '0);

        // Reload during MUL, held high for three cycles.
        load(to_redun(x_a), x_a, 2, 1);
        run(30);
        load(to_redun(x_b), x_b, 2, 3);
        run(2 * L);
        chk("queue drained reload", RW'(exp_q.size()), '0);

        // Reload sampled on the REDUCE edge suppresses that strobe.
        load(to_redun(x_a), x_a, 1, 1);
        run(L - 1);
        load(to_redun(r_mont), r_mont, 1, 1);
        run(L);
        chk("queue drained reduce abort", RW'(exp_q.size()), '0);

        // Asynchronous reset while a strobe is on the outputs.
        load(to_redun(x_a), x_a, 2, 1);
        run(L);
        #2 rst = 1'b0;
        #1;
        chk("async rst o_val", RW'(mul_v), '0);
        chk("async rst o_mul", mul, '0);
        armed = 1'b0;
        exp_q.delete();
        val_in = 1'b1;
        run(2);
        val_in = 1'b0;
        rst    = 1'b1;
        run(2 * L);
        chk("post reset idle state", RW'(dbg_state), RW'(2'd0));
        chk("post reset o_mul", mul, '0);

        load(to_redun(x_b), x_b, 1, 1);
        run(L);
        chk("queue drained restart", RW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/redun_mont.md
Name: redun_mont

Overview:
- Free-running Montgomery modular squarer for the VDF datapath; operands and results are carried in redundant (carry-save word) form.
- A single load pulse seeds the loop. The block then repeatedly squares its own previous result, computing x(k+1) = x(k)^2 · R^-1 mod P.
- Each result is presented with a one-cycle valid strobe.
- It sits between the VDF controller, which seeds and counts iterations, and result capture.

Parameters:
- DAT_BITS, 1024: modulus width in bits.
- WRD_BITS, 16: base word width of the redundant representation.
- NUM_WRDS, DAT_BITS/WRD_BITS+1 (65): number of redundant words.
- P, package modulus constant: odd modulus with P < 2^DAT_BITS.
- R, 2^(WRD_BITS·NUM_WRDS): Montgomery radix; to_mont/from_mont in the package use the same R.

Ports:
- i_clk, in, 1: clock; all logic on the rising edge.
- i_rst, in, 1: reset, asynchronous, active-low.
- i_sq, in, NUM_WRDS×(WRD_BITS+1): seed value in redundant form; value = Σ word[i]·2^(WRD_BITS·i).
- i_val, in, 1: load strobe; i_sq is sampled when this is high.
- o_mul, out, NUM_WRDS×(WRD_BITS+1): latest squaring result in redundant form.
- o_val, out, 1: one-cycle strobe marking a new o_mul.

Behaviour:
- Reset (i_rst=0, asynchronous): o_val=0, o_mul=0, FSM=IDLE, all accumulators cleared. While i_rst is low, i_val is ignored.
- FSM states are IDLE, MUL and REDUCE.
- IDLE → MUL on i_val=1:
  - Latch i_sq, converted to binary by carry resolution.
  - The input value is < P, given by the caller.
- MUL: word-serial CIOS Montgomery step, one word per cycle for NUM_WRDS cycles:
  - t = (t + a[i]·a + m·P) / 2^WRD_BITS.
  - m = ((t + a[i]·a) mod 2^WRD_BITS) · P' mod 2^WRD_BITS.
  - P' = −P^-1 mod 2^WRD_BITS, a derived constant.
- REDUCE: one cycle.
  - If t ≥ P then t = t − P, giving a result in [0, P).
  - Drive o_mul with t, every word < 2^WRD_BITS and the top carry bits 0.
  - Pulse o_val=1 for exactly one cycle.
  - Feed t back as the next operand and return to MUL.
- Latency: L = NUM_WRDS+2 cycles.
  - First o_val comes L cycles after the i_val sample edge.
  - Subsequent o_val pulses come exactly every L cycles, indefinitely.
- o_mul holds its value between strobes. Value(o_mul) must equal exactly x·x·R^-1 mod P, fully reduced.
- i_val while in MUL/REDUCE: abort the current iteration, reload from i_sq and restart the latency count. No o_val is issued for the aborted iteration.
- i_val held high for several cycles: each asserted cycle reloads; counting starts after the last one.
- Input words may carry the extra (WRD_BITS+1) bit. Resolve carries before use; any redundant encoding of the same value < P gives identical results.
- Multiplier width: WRD_BITS × DAT_BITS partial product per cycle. Size accumulator t to DAT_BITS+WRD_BITS+2 bits so no overflow occurs.
- There is no stop input. The caller counts o_val pulses and ignores surplus results.

Test Plan:
- Seed i_sq = to_redun(to_mont(1)) = R mod P → o_mul value = R mod P on every strobe, strobes spaced exactly L cycles.
- Seed 0 → o_mul = 0 on every strobe; o_val period L; first strobe L cycles after load.
- Seed to_mont(a), with a a random 1024-bit value mod P (seed 2), for 127 strobes → each value(o_mul) equals the model fe_mul_mont of the previous value; from_mont of the final result equals a^(2^127) mod P.
- Seed with redundant encoding (extra carry bits set, same value) → outputs bit-identical to the canonical-encoded seed.
- Reload mid-run: apply i_val with a new seed during MUL → no stale strobe; next strobe L cycles later carries the new seed squared.
- Reset low mid-run → o_val and o_mul go to 0 immediately (asynchronously); no strobes until a new i_val after reset release.
